uart_bus_responder: RTL
=======================

# uart_bus_responder

Synthesizable model of the board's parallel-bus UART chip: the device side of the rdn/wrn/data_ready/tbre/tsre handshake that the FPGA bus master drives. It deserializes an 8N1 serial stream on `rxd` into a one-byte receive holding register exposed on `data[7:0]`. It serializes bytes written over `data[7:0]` onto `txd`. It sits opposite the UART echo/controller logic on the shared 16-bit `data` bus, for loopback builds and for closed-loop benches.

## Interface
Parameters:
- `CLK_HZ`, 11059200: clock frequency in Hz.
- `BAUD`, 115200: serial bit rate.
- `DIV`, CLK_HZ/BAUD (96): clock cycles per bit. Must be ≥ 4.

Ports (one clock; reset is synchronous and active-high):
- `CLK` in 1: system clock, 11 MHz.
- `RST` in 1: synchronous reset, active-high.
- `rdn` in 1: read strobe from the master, active-low.
- `wrn` in 1: write strobe from the master, active-low. Data is latched on the rising edge.
- `data` inout 16: shared bus. Driven only during reads; `[15:8]` is driven as 0.
- `data_ready` out 1: receive holding register full.
- `tbre` out 1: transmit buffer empty.
- `tsre` out 1: transmit shifter empty (line idle).
- `rxd` in 1: serial input, asynchronous.
- `txd` out 1: serial output, idles high.
- `overrun` out 1: sticky flag; a byte arrived while `data_ready` was 1. Cleared by a read.
- `frame_err` out 1: one-cycle pulse when a stop bit is sampled as 0.

## Operation
- Reset values: `data_ready`=0, `tbre`=1, `tsre`=1, `txd`=1, `overrun`=0, `frame_err`=0, `data`=Z. Both FSMs go to IDLE and the baud counters go to 0. Reset mid-frame abandons the frame; no partial byte is delivered.
- `rxd` passes through a 2-FF synchronizer. `rdn` and `wrn` are sampled directly, because the master is synchronous to `CLK`.
- RX FSM states:
  - R_IDLE: on a synchronized falling edge of `rxd`, go to R_START.
  - R_START: after DIV/2 cycles, sample `rxd`. If 1, treat it as a glitch and return to R_IDLE. If 0, go to R_DATA.
  - R_DATA: sample every DIV cycles, 8 bits, LSB first, into a shift register.
  - R_STOP: sample after DIV cycles.
    - Stop bit 1: load `rx_hold` and set `data_ready`=1. If `data_ready` was already 1, overwrite `rx_hold` and set `overrun`.
    - Stop bit 0: discard the byte, pulse `frame_err`, and leave `rx_hold` and `data_ready` unchanged.
  - From R_STOP, return to R_IDLE.
- Read: while `rdn`=0 and `wrn`=1, drive `data` = {8'h00, rx_hold} combinationally; otherwise `data` is Z. On the first cycle `rdn` is sampled 0, clear `data_ready` and `overrun` (registered). `rx_hold` stays stable while `rdn` is low.
  - A read with `data_ready`=0 returns the stale `rx_hold` and has no other effect.
  - If an RX load and the `data_ready` clear fall on the same cycle, the load wins: `data_ready` stays 1.
- Write: on the cycle where `wrn` is sampled 1 and was 0 the previous cycle, latch `data[7:0]` into `tx_hold` and set `tbre`=0 and `tsre`=0.
  - A write while `tbre`=0 is ignored; `tx_hold` is kept.
  - If `rdn` and `wrn` are both low, the bus is not driven and the write is still processed.
- TX FSM states:
  - T_IDLE: when `tbre`=0, move `tx_hold` into the shifter, set `tbre`=1, and go to T_START.
  - T_START: `txd`=0 for DIV cycles.
  - T_DATA: 8 bits, LSB first, DIV cycles each.
  - T_STOP: `txd`=1 for DIV cycles. At the end:
    - if `tbre`=0 (a new byte is pending), reload the shifter and go to T_START with no idle gap;
    - otherwise set `tsre`=1 and go to T_IDLE.

## Timing
- Write: the `wrn` rising edge is detected at cycle t.
  - t+1: `tbre`=0, `tsre`=0.
  - t+2: `tbre`=1 and the start bit begins on `txd`.
  - t+2+10·DIV: `tsre`=1.
- RX: `data_ready` rises 1 cycle after the mid-stop-bit sample. That is about 9.5·DIV+3 cycles after the `rxd` falling edge, including the synchronizer.
- Read: `data` is valid in the same cycle `rdn` falls. `data_ready` falls 1 cycle after `rdn` is first sampled low.
- Bit period is exactly DIV cycles. The counter counts 0..DIV-1 and wraps.

## Structure
- Shared package `uart_defs`:
  - RX state encodings (R_IDLE..R_STOP) and TX state encodings (T_IDLE..T_STOP);
  - `DATA_BITS`=8;
  - the `HIGH` Z-bus constant.
- One sub-module, `uart_baud_tick`: a DIV-cycle counter with a synchronous restart input, a half-period option for start-bit centering, and a `tick` output. It is instantiated twice, once for RX and once for TX.
- The bus decode, RX FSM and TX FSM stay in the top module.

## Test plan
All scenarios use DIV=16.
- Reset: assert `RST` for 2 cycles → `data_ready`=0, `tbre`=1, `tsre`=1, `txd`=1, `data`=Z.
- RX byte 8'hA5 on `rxd` → `data_ready` goes to 1. Then hold `rdn` low for 2 cycles → `data`=16'h00A5, and `data_ready`=0 one cycle after `rdn` falls.
- Two RX bytes 8'h12 then 8'h34 with no read in between → `overrun`=1 and a read returns 16'h0034. After the read, `overrun`=0.
- RX 8'h55 with the stop bit forced to 0 → `frame_err` pulses for 1 cycle, `data_ready` stays 0, and `rx_hold` is unchanged.
- Write 16'h003C via `wrn` low 1 cycle, then high → `tbre` low for exactly 1 cycle, and `txd` = 0,0,0,1,1,1,1,0,0,1 at 16-cycle spacing. `tsre`=1 160 cycles after the start bit begins.
- Back-to-back writes 8'h01 then 8'h02, the second issued while the first is shifting → no idle gap between frames. A third write issued while `tbre`=0 is ignored.

Source files
------------

// File: rtl/uart_defs.sv
// Shared definitions for the bus-side UART model: FSM encodings, frame width
// and the released-bus value.
package uart_defs;

    localparam int DATA_BITS = 8;
    localparam logic [15:0] HIGH = 16'hzzzz;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        T_IDLE,
        T_START,
        T_DATA,
        T_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..DIV-1 and pulses tick on the last count.
// Restart can preload half a period so the first tick lands mid start bit.
module uart_baud_tick #(
    parameter int DIV = 96
) (
    input  logic clk,
    input  logic srst,
    input  logic restart_i,
    input  logic half_i,
    output logic tick_o
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST       = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_START = CW'(DIV - DIV / 2);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart_i) begin
            cnt_d = half_i ? HALF_START : '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = !restart_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_bus_responder.sv
// Device side of the parallel-bus UART: 8N1 receiver with a holding register
// read over the shared bus, and a double-buffered 8N1 transmitter fed by bus writes.
module uart_bus_responder
    import uart_defs::*;
#(
    parameter int CLK_HZ = 11059200,
    parameter int BAUD   = 115200,
    parameter int DIV    = CLK_HZ / BAUD
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        rdn,
    input  logic        wrn,
    inout  wire  [15:0] data,
    output logic        data_ready,
    output logic        tbre,
    output logic        tsre,
    input  logic        rxd,
    output logic        txd,
    output logic        overrun,
    output logic        frame_err
);

    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    rx_state_t rx_state_q, rx_state_d;
    tx_state_t tx_state_q, tx_state_d;

    logic [2:0]           rxd_sync_q;
    logic                 rdn_q, wrn_q;
    logic                 rx_bit, rx_fall, rd_first, wr_rise, bus_drive;
    logic [DATA_BITS-1:0] rx_shift_q, rx_hold_q, tx_hold_q, tx_shift_q;
    logic [BW-1:0]        rx_cnt_q, tx_cnt_q;
    logic                 rx_tick, tx_tick, rx_restart, tx_restart;
    logic                 rx_sample, rx_load, rx_ferr;
    logic                 tx_load, tx_shift_en, tx_done, txd_d;
    logic                 data_ready_q, overrun_q, frame_err_q, tbre_q, tsre_q;
    logic                 unused_data_hi;

    assign unused_data_hi = ^data[15:8];

    // Bit [0] is the metastability stage; [1] is the usable sample, [2] its predecessor.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rxd_sync_q <= '1;
            rdn_q      <= 1'b1;
            wrn_q      <= 1'b1;
        end else begin
            rxd_sync_q <= {rxd_sync_q[1:0], rxd};
            rdn_q      <= rdn;
            wrn_q      <= wrn;
        end
    end

    assign rx_bit    = rxd_sync_q[1];
    assign rx_fall   = rxd_sync_q[2] & ~rxd_sync_q[1];
    assign rd_first  = !rdn && rdn_q;
    assign wr_rise   = wrn && !wrn_q;
    assign bus_drive = !rdn && wrn;
    assign data      = bus_drive ? {8'h00, rx_hold_q} : HIGH;

    uart_baud_tick #(.DIV(DIV)) u_rx_baud (
        .clk       (CLK),
        .srst      (RST),
        .restart_i (rx_restart),
        .half_i    (1'b1),
        .tick_o    (rx_tick)
    );

    uart_baud_tick #(.DIV(DIV)) u_tx_baud (
        .clk       (CLK),
        .srst      (RST),
        .restart_i (tx_restart),
        .half_i    (1'b0),
        .tick_o    (tx_tick)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_state_q <= R_IDLE;
            tx_state_q <= T_IDLE;
        end else begin
            rx_state_q <= rx_state_d;
            tx_state_q <= tx_state_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            R_IDLE:  if (rx_fall) rx_state_d = R_START;
            R_START: if (rx_tick) rx_state_d = rx_bit ? R_IDLE : R_DATA;
            R_DATA:  if (rx_tick && rx_cnt_q == LAST_BIT) rx_state_d = R_STOP;
            R_STOP:  if (rx_tick) rx_state_d = R_IDLE;
            default: rx_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        rx_restart = (rx_state_q == R_IDLE);
        rx_sample  = (rx_state_q == R_DATA) && rx_tick;
        rx_load    = (rx_state_q == R_STOP) && rx_tick && rx_bit;
        rx_ferr    = (rx_state_q == R_STOP) && rx_tick && !rx_bit;
    end

    // A load in the same cycle as the read-clear leaves data_ready set.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_shift_q   <= '0;
            rx_cnt_q     <= '0;
            rx_hold_q    <= '0;
            data_ready_q <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            frame_err_q <= rx_ferr;
            if (rx_restart) begin
                rx_cnt_q <= '0;
            end else if (rx_sample) begin
                rx_shift_q <= {rx_bit, rx_shift_q[DATA_BITS-1:1]};
                rx_cnt_q   <= rx_cnt_q + BW'(1);
            end
            if (rd_first) begin
                data_ready_q <= 1'b0;
                overrun_q    <= 1'b0;
            end
            if (rx_load) begin
                rx_hold_q    <= rx_shift_q;
                data_ready_q <= 1'b1;
                if (data_ready_q) overrun_q <= 1'b1;
            end
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            T_IDLE:  if (!tbre_q) tx_state_d = T_START;
            T_START: if (tx_tick) tx_state_d = T_DATA;
            T_DATA:  if (tx_tick && tx_cnt_q == LAST_BIT) tx_state_d = T_STOP;
            T_STOP:  if (tx_tick) tx_state_d = tbre_q ? T_IDLE : T_START;
            default: tx_state_d = T_IDLE;
        endcase
    end

    always_comb begin
        tx_restart  = (tx_state_q == T_IDLE);
        tx_load     = !tbre_q && ((tx_state_q == T_IDLE) || ((tx_state_q == T_STOP) && tx_tick));
        tx_shift_en = (tx_state_q == T_DATA) && tx_tick;
        tx_done     = (tx_state_q == T_STOP) && tx_tick && tbre_q;
        case (tx_state_q)
            T_START: txd_d = 1'b0;
            T_DATA:  txd_d = tx_shift_q[0];
            default: txd_d = 1'b1;
        endcase
    end

    // Writes are only accepted while tbre is set, so they never collide with tx_load.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_hold_q  <= '0;
            tx_shift_q <= '0;
            tx_cnt_q   <= '0;
            tbre_q     <= 1'b1;
            tsre_q     <= 1'b1;
        end else begin
            if (tx_load) begin
                tx_shift_q <= tx_hold_q;
                tx_cnt_q   <= '0;
                tbre_q     <= 1'b1;
            end else if (tx_shift_en) begin
                tx_shift_q <= {1'b0, tx_shift_q[DATA_BITS-1:1]};
                tx_cnt_q   <= tx_cnt_q + BW'(1);
            end
            if (tx_done) tsre_q <= 1'b1;
            if (wr_rise && tbre_q) begin
                tx_hold_q <= data[DATA_BITS-1:0];
                tbre_q    <= 1'b0;
                tsre_q    <= 1'b0;
            end
        end
    end

    assign data_ready = data_ready_q;
    assign overrun    = overrun_q;
    assign frame_err  = frame_err_q;
    assign tbre       = tbre_q;
    assign tsre       = tsre_q;
    assign txd        = txd_d;

endmodule
